div_unit: RTL and testbench

Iterative integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions in the single-cycle core's execute stage. It sits beside the ALU and receives the same operand-mux outputs and instruction word. It stalls the core through a busy/done handshake while producing one quotient bit per cycle. The result goes to the writeback mux in place of the ALU output.

---
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 167 ++++++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Execute-stage handshake between the core and the iterative divide unit.
interface div_unit_if #(parameter int XLEN = 32);
  logic            div_start;
  logic [31:0]     inst_CCD;
  logic [XLEN-1:0] IE_mux1_value;
  logic [XLEN-1:0] IE_mux2_value;
  logic            div_kill;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_start, inst_CCD, IE_mux1_value, IE_mux2_value, div_kill,
    input  div_busy, div_done, div_result
  );

  modport slave (
    input  div_start, inst_CCD, IE_mux1_value, IE_mux2_value, div_kill,
    output div_busy, div_done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU restoring divider, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish divide-by-zero/overflow in one cycle.
module div_unit (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Whole-word match: OP opcode, funct7=0000001, funct3[2]=1.
  localparam logic [31:0] DEC_MASK = 32'hFE00_407F;
  localparam logic [31:0] DEC_PAT  = 32'h0200_4033;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [32:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic        r_qneg;
  logic        r_rneg;
  logic        r_is_rem;
  logic        r_dvz;
  logic        r_ovf;
  logic [31:0] r_result;

  logic        w_valid;
  logic        w_signed;
  logic        w_is_rem;
  logic        w_accept;
  logic        w_b_zero;
  logic        w_ovf_in;
  logic        w_special;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [33:0] w_shift;
  logic [33:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_fix_result;
  logic [31:0] w_early_result;

  assign w_a       = div_if.IE_mux1_value;
  assign w_b       = div_if.IE_mux2_value;
  assign w_valid   = ((div_if.inst_CCD & DEC_MASK) == DEC_PAT);
  assign w_signed  = ~div_if.inst_CCD[12];
  assign w_is_rem  = div_if.inst_CCD[13];
  assign w_accept  = (r_state == IDLE) && div_if.div_start && !div_if.div_kill && w_valid;
  assign w_b_zero  = (w_b == 32'd0);
  assign w_ovf_in  = w_signed && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_special = w_b_zero || w_ovf_in;

  assign w_shift = {r_rem, r_dvd[31]};
  assign w_trial = w_shift - {2'b00, r_dvs};
  assign w_qbit  = ~w_trial[33];

  assign w_q_fix = r_dvz ? 32'hFFFF_FFFF :
                   r_ovf ? 32'h8000_0000 :
                   r_qneg ? (~r_dvd + 32'd1) : r_dvd;
  assign w_r_fix = r_ovf ? 32'd0 :
                   r_rneg ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
  assign w_fix_result   = r_is_rem ? w_r_fix : w_q_fix;
  assign w_early_result = w_b_zero ? (w_is_rem ? w_a : 32'hFFFF_FFFF)
                                   : (w_is_rem ? 32'd0 : 32'h8000_0000);

  assign div_if.div_busy   = (r_state != IDLE);
  assign div_if.div_done   = (r_state == DONE);
  assign div_if.div_result = r_result;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic; kill from any busy state returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_EARLY_OUT_EN
          w_next = w_special ? DONE : CALC;
`else
          w_next = CALC;
`endif
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (div_if.div_kill)  w_next = IDLE;
        else if (r_cnt == 5'd0) w_next = FIXUP;
        else                  w_next = CALC;
      end
      FIXUP: begin
        if (div_if.div_kill) w_next = IDLE;
        else                 w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand latch, shift/subtract iteration, sign fixup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_rem    <= 33'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_is_rem <= 1'b0;
      r_dvz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd    <= (w_signed && w_a[31]) ? (~w_a + 32'd1) : w_a;
            r_dvs    <= (w_signed && w_b[31]) ? (~w_b + 32'd1) : w_b;
            r_qneg   <= w_signed && (w_a[31] ^ w_b[31]);
            r_rneg   <= w_signed && w_a[31];
            r_is_rem <= w_is_rem;
            r_dvz    <= w_b_zero;
            r_ovf    <= w_ovf_in;
            r_rem    <= 33'd0;
            r_cnt    <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
            if (w_special) r_result <= w_early_result;
`endif
          end
        end
        CALC: begin
          if (!div_if.div_kill) begin
            r_rem <= w_qbit ? w_trial[32:0] : w_shift[32:0];
            r_dvd <= {r_dvd[30:0], w_qbit};
            if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          end
        end
        FIXUP: begin
          if (!div_if.div_kill) r_result <= w_fix_result;
        end
        default: begin
        end
      endcase
    end
  end

`ifndef DIV_EARLY_OUT_EN
  logic w_unused;
  assign w_unused = ^{w_special, w_early_result};
`endif

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset;
  div_unit_if dif();

  div_unit dut (.clk(clk), .reset(reset), .div_if(dif));

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [31:0] last_res = 32'd0;

  always @(negedge clk) if (dif.div_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (f3[0]) begin
      q = a / b; r = a % b;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return special ? 34 : 34;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    dif.div_start     = 1'b1;
    dif.inst_CCD      = mk_inst(7'b0000001, f3);
    dif.IE_mux1_value = a;
    dif.IE_mux2_value = b;
  endtask

  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (dif.div_done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = ref_res(f3, a, b);
    drive(f3, a, b);
    tick();
    dif.div_start = 1'b0;
    wait_done(1, lat);
    check({tag, " latency"}, 32'(lat), 32'(ref_lat(f3, a, b)));
    check({tag, " result"}, dif.div_result, exp);
    tick();
    check({tag, " done pulse"}, {31'd0, dif.div_done}, 32'd0);
    check({tag, " busy end"}, {31'd0, dif.div_busy}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    int d0, lat;
    logic [2:0]  f3;
    logic [31:0] a, b;

    reset = 1'b1;
    dif.div_start = 1'b0; dif.div_kill = 1'b0;
    dif.inst_CCD = 32'd0; dif.IE_mux1_value = 32'd0; dif.IE_mux2_value = 32'd0;
    repeat (2) tick();
    check("reset busy", {31'd0, dif.div_busy}, 32'd0);
    check("reset done", {31'd0, dif.div_done}, 32'd0);
    check("reset result", dif.div_result, 32'd0);
    reset = 1'b0;
    tick();

    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7);
    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0);
    run_op("REMU 5/0", 3'b111, 32'd5, 32'd0);
    run_op("DIV -9/0", 3'b100, 32'hFFFF_FFF7, 32'd0);
    run_op("REM -9/0", 3'b110, 32'hFFFF_FFF7, 32'd0);
    run_op("DIVU ovf pattern", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b);
    end

    // Kill mid-CALC
    drive(3'b101, 32'd50, 32'd5);
    tick();
    dif.div_start = 1'b0;
    repeat (9) tick();
    d0 = done_cnt;
    dif.div_kill = 1'b1;
    tick();
    dif.div_kill = 1'b0;
    check("kill busy", {31'd0, dif.div_busy}, 32'd0);
    check("kill result held", dif.div_result, last_res);
    repeat (40) tick();
    check("kill no done", 32'(done_cnt), 32'(d0));
    check("kill result still held", dif.div_result, last_res);
    run_op("DIVU 9/3 after kill", 3'b101, 32'd9, 32'd3);

    // Kill wins over start in IDLE
    drive(3'b101, 32'd10, 32'd2);
    dif.div_kill = 1'b1;
    tick();
    dif.div_start = 1'b0; dif.div_kill = 1'b0;
    check("kill+start busy", {31'd0, dif.div_busy}, 32'd0);

    // Non-M encoding is ignored
    d0 = done_cnt;
    dif.div_start = 1'b1;
    dif.inst_CCD = mk_inst(7'b0000000, 3'b000);
    tick();
    dif.div_start = 1'b0;
    check("ADD busy", {31'd0, dif.div_busy}, 32'd0);
    repeat (40) tick();
    check("ADD no done", 32'(done_cnt), 32'(d0));
    check("ADD result held", dif.div_result, last_res);

    // Second start during CALC is ignored
    drive(3'b101, 32'd1000, 32'd10);
    tick();
    dif.div_start = 1'b0;
    repeat (5) tick();
    drive(3'b100, 32'd77, 32'd7);
    tick();
    dif.div_start = 1'b0;
    wait_done(7, lat);
    check("restart latency", 32'(lat), 32'd34);
    check("restart result", dif.div_result, ref_res(3'b101, 32'd1000, 32'd10));
    tick();
    last_res = ref_res(3'b101, 32'd1000, 32'd10);

    // Asynchronous reset mid-operation
    drive(3'b101, 32'hFFFF_FFFF, 32'd3);
    tick();
    dif.div_start = 1'b0;
    repeat (19) tick();
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("async reset busy", {31'd0, dif.div_busy}, 32'd0);
    check("async reset done", {31'd0, dif.div_done}, 32'd0);
    check("async reset result", dif.div_result, 32'd0);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("reset no done", 32'(done_cnt), 32'(d0));
    run_op("DIV after reset", 3'b100, 32'd12345, 32'hFFFF_FFFD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
